ps2_ascii: RTL and testbench
============================

PS2_ASCII -- requirements
Module: ps2_ascii

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, 2..16.
REQ-002 clk  in  1  system clock (clock_50 domain); all state SHALL update on its rising edge.
REQ-003 res  in  1  reset, asynchronous, active-high; SHALL clear all state immediately.
REQ-004 scan_code  in  8  raw PS/2 set-2 byte from the receiver.
REQ-005 scan_valid  in  1  one-cycle pulse, scan_code valid.
REQ-006 clr  in  1  one-cycle pulse from the address decoder on a CPU read of the key data register.
REQ-007 kbd  out  8  {avail, head[6:0]}; SHALL be 8'h00 when the FIFO is empty.
REQ-008 kbd_strb  out  8  {avail, 7'b0}.
REQ-009 overflow  out  1  sticky; a character was dropped.
REQ-010 caps  out  1  caps-lock state, for an LED.

Function
REQ-011 Prefix FSM states SHALL be IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0,F0).
REQ-012 Transitions: E0 in IDLE -> EXT; F0 in IDLE -> BRK; F0 in EXT -> EXT_BRK; any other byte is consumed and returns to IDLE.
REQ-013 Modifier handling: make/break of 12h or 59h SHALL set/clear shift_l/shift_r; 14h (also E0 14h) SHALL set/clear ctrl.
REQ-014 Caps lock: make of 58h SHALL toggle caps; its break SHALL be ignored.
REQ-015 Letter makes SHALL emit upper case when (shift XOR caps), otherwise lower case; ctrl+letter SHALL emit the upper-case code AND 1Fh.
REQ-016 Digit and punctuation makes SHALL emit the US-layout shifted/unshifted code; caps SHALL NOT affect them.
REQ-017 Fixed codes: 5Ah and E0 5Ah -> 0Dh; 66h -> 08h; 76h -> 1Bh; 29h -> 20h; 0Dh (tab) -> 09h.
REQ-018 Unmapped makes, all other extended makes, and all breaks SHALL emit nothing.
REQ-019 Typematic repeats (same make without a break) SHALL each emit a character.
REQ-020 Latency: scan_valid at edge N SHALL write the FIFO at edge N+1; with the FIFO previously empty, kbd SHALL show the character after edge N+1.
REQ-021 clr with the FIFO non-empty SHALL pop one entry at the next edge; clr on empty SHALL be ignored.
REQ-022 Push when full without a simultaneous pop SHALL drop the character and set overflow.
REQ-023 Simultaneous push and pop SHALL both take effect, including when full; occupancy is unchanged and overflow SHALL NOT be set.
REQ-024 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a count of log2(DEPTH)+1 bits.
REQ-025 overflow SHALL clear only on res.

Reset
REQ-026 On res: FSM to IDLE; shift_l, shift_r, ctrl, caps and overflow to 0; FIFO empty; kbd and kbd_strb to 8'h00.
REQ-027 A prefix sequence interrupted by res SHALL be discarded; the next byte after reset SHALL be decoded from IDLE.

Structure
REQ-028 Package kbd_pkg SHALL hold the prefix-state enum and scan-code constants: E0, F0, LSHIFT, RSHIFT, CTRL, CAPS, ENTER, BKSP, ESC, SPACE, TAB.
REQ-029 The FIFO SHALL be a separate sub-module kbd_fifo, parameterized by DEPTH and width 7, with push, pop, full, empty, head ports.
REQ-030 The scan-to-ASCII table SHALL be a combinational function in ps2_ascii, with a registered output feeding the FIFO push.

Verification
REQ-031 Send 1Ch -> kbd = E1h ('a'|80h) two edges later; kbd_strb = 80h; clr pulse -> kbd = 00h.
REQ-032 Send 12h, 1Ch, F0 1Ch, F0 12h, then 1Ch -> FIFO holds 41h then 61h; the breaks emit nothing.
REQ-033 Send 58h, F0 58h, 1Ch -> caps = 1, emits 41h; then 12h, 1Ch -> emits 61h.
REQ-034 Send 14h, 21h -> emits 03h; send E0 5Ah -> emits 0Dh; send E0 75h -> nothing.
REQ-035 With DEPTH=4, push five characters -> overflow = 1 and the first four are read back in order; with the FIFO full, push plus clr in the same cycle -> count stays 4 and overflow is unchanged.
REQ-036 Assert res after E0 F0 -> outputs 00h; the next byte 1Ch emits 61h.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared prefix-state encoding and PS/2 set-2 scan-code constants
// for the keyboard-to-ASCII front end.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } pfx_e;

  localparam logic [7:0] E0     = 8'hE0;
  localparam logic [7:0] F0     = 8'hF0;
  localparam logic [7:0] LSHIFT = 8'h12;
  localparam logic [7:0] RSHIFT = 8'h59;
  localparam logic [7:0] CTRL   = 8'h14;
  localparam logic [7:0] CAPS   = 8'h58;
  localparam logic [7:0] ENTER  = 8'h5A;
  localparam logic [7:0] BKSP   = 8'h66;
  localparam logic [7:0] ESC    = 8'h76;
  localparam logic [7:0] SPACE  = 8'h29;
  localparam logic [7:0] TAB    = 8'h0D;

endpackage

// File: rtl/kbd_fifo.sv
// Small character FIFO between the decoder and the CPU key register.
// Occupancy counter carries one extra bit so full and empty stay distinct.
module kbd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [AW:0]      cnt_q;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_MAX);
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_ascii.sv
// PS/2 set-2 scan-code decoder: prefix FSM, modifier tracking and
// US-layout ASCII translation feeding a CPU-readable character FIFO.
import kbd_pkg::*;

module ps2_ascii #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       clr,
  output logic [7:0] kbd,
  output logic [7:0] kbd_strb,
  output logic       overflow,
  output logic       caps
);

  function automatic logic [7:0] scan2ascii(
    input logic [7:0] sc,
    input logic       sh,
    input logic       cp,
    input logic       ct
  );
    logic       l;
    logic       p;
    logic [6:0] un;
    logic [6:0] sv;
    logic [6:0] up;
    l  = 1'b0;
    p  = 1'b0;
    un = 7'h00;
    sv = 7'h00;
    case (sc)
      8'h1C: {l, un} = {1'b1, 7'h61};
      8'h32: {l, un} = {1'b1, 7'h62};
      8'h21: {l, un} = {1'b1, 7'h63};
      8'h23: {l, un} = {1'b1, 7'h64};
      8'h24: {l, un} = {1'b1, 7'h65};
      8'h2B: {l, un} = {1'b1, 7'h66};
      8'h34: {l, un} = {1'b1, 7'h67};
      8'h33: {l, un} = {1'b1, 7'h68};
      8'h43: {l, un} = {1'b1, 7'h69};
      8'h3B: {l, un} = {1'b1, 7'h6A};
      8'h42: {l, un} = {1'b1, 7'h6B};
      8'h4B: {l, un} = {1'b1, 7'h6C};
      8'h3A: {l, un} = {1'b1, 7'h6D};
      8'h31: {l, un} = {1'b1, 7'h6E};
      8'h44: {l, un} = {1'b1, 7'h6F};
      8'h4D: {l, un} = {1'b1, 7'h70};
      8'h15: {l, un} = {1'b1, 7'h71};
      8'h2D: {l, un} = {1'b1, 7'h72};
      8'h1B: {l, un} = {1'b1, 7'h73};
      8'h2C: {l, un} = {1'b1, 7'h74};
      8'h3C: {l, un} = {1'b1, 7'h75};
      8'h2A: {l, un} = {1'b1, 7'h76};
      8'h1D: {l, un} = {1'b1, 7'h77};
      8'h22: {l, un} = {1'b1, 7'h78};
      8'h35: {l, un} = {1'b1, 7'h79};
      8'h1A: {l, un} = {1'b1, 7'h7A};
      8'h16: {p, un, sv} = {1'b1, 7'h31, 7'h21};
      8'h1E: {p, un, sv} = {1'b1, 7'h32, 7'h40};
      8'h26: {p, un, sv} = {1'b1, 7'h33, 7'h23};
      8'h25: {p, un, sv} = {1'b1, 7'h34, 7'h24};
      8'h2E: {p, un, sv} = {1'b1, 7'h35, 7'h25};
      8'h36: {p, un, sv} = {1'b1, 7'h36, 7'h5E};
      8'h3D: {p, un, sv} = {1'b1, 7'h37, 7'h26};
      8'h3E: {p, un, sv} = {1'b1, 7'h38, 7'h2A};
      8'h46: {p, un, sv} = {1'b1, 7'h39, 7'h28};
      8'h45: {p, un, sv} = {1'b1, 7'h30, 7'h29};
      8'h0E: {p, un, sv} = {1'b1, 7'h60, 7'h7E};
      8'h4E: {p, un, sv} = {1'b1, 7'h2D, 7'h5F};
      8'h55: {p, un, sv} = {1'b1, 7'h3D, 7'h2B};
      8'h54: {p, un, sv} = {1'b1, 7'h5B, 7'h7B};
      8'h5B: {p, un, sv} = {1'b1, 7'h5D, 7'h7D};
      8'h5D: {p, un, sv} = {1'b1, 7'h5C, 7'h7C};
      8'h4C: {p, un, sv} = {1'b1, 7'h3B, 7'h3A};
      8'h52: {p, un, sv} = {1'b1, 7'h27, 7'h22};
      8'h41: {p, un, sv} = {1'b1, 7'h2C, 7'h3C};
      8'h49: {p, un, sv} = {1'b1, 7'h2E, 7'h3E};
      8'h4A: {p, un, sv} = {1'b1, 7'h2F, 7'h3F};
      ENTER: {p, un, sv} = {1'b1, 7'h0D, 7'h0D};
      BKSP:  {p, un, sv} = {1'b1, 7'h08, 7'h08};
      ESC:   {p, un, sv} = {1'b1, 7'h1B, 7'h1B};
      SPACE: {p, un, sv} = {1'b1, 7'h20, 7'h20};
      TAB:   {p, un, sv} = {1'b1, 7'h09, 7'h09};
      default: ;
    endcase
    up = un & 7'h5F;
    if (l) begin
      if (ct) return {1'b1, up & 7'h1F};
      return {1'b1, (sh ^ cp) ? up : un};
    end
    if (p) return {1'b1, sh ? sv : un};
    return 8'h00;
  endfunction

  pfx_e       state_q;
  logic       shift_l_q;
  logic       shift_r_q;
  logic       ctrl_q;
  logic       caps_q;
  logic       ovf_q;
  logic       push_q;
  logic [6:0] char_q;
  logic [7:0] tbl;
  logic       full;
  logic       empty;
  logic [6:0] head;

  always_comb begin
    tbl = scan2ascii(scan_code, shift_l_q | shift_r_q, caps_q, ctrl_q);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
      ctrl_q    <= 1'b0;
      caps_q    <= 1'b0;
      ovf_q     <= 1'b0;
      push_q    <= 1'b0;
      char_q    <= '0;
    end else begin
      push_q <= 1'b0;
      // full implies non-empty, so clr here always frees a slot
      if (push_q && full && !clr) ovf_q <= 1'b1;
      if (scan_valid) begin
        state_q <= IDLE;
        unique case (state_q)
          IDLE: begin
            if (scan_code == E0) begin
              state_q <= EXT;
            end else if (scan_code == F0) begin
              state_q <= BRK;
            end else begin
              case (scan_code)
                LSHIFT:  shift_l_q <= 1'b1;
                RSHIFT:  shift_r_q <= 1'b1;
                CTRL:    ctrl_q    <= 1'b1;
                CAPS:    caps_q    <= ~caps_q;
                default: begin
                  push_q <= tbl[7];
                  char_q <= tbl[6:0];
                end
              endcase
            end
          end
          EXT: begin
            if (scan_code == F0) begin
              state_q <= EXT_BRK;
            end else if (scan_code == CTRL) begin
              ctrl_q <= 1'b1;
            end else if (scan_code == ENTER) begin
              push_q <= 1'b1;
              char_q <= 7'h0D;
            end
          end
          BRK: begin
            case (scan_code)
              LSHIFT:  shift_l_q <= 1'b0;
              RSHIFT:  shift_r_q <= 1'b0;
              CTRL:    ctrl_q    <= 1'b0;
              default: ;
            endcase
          end
          EXT_BRK: begin
            if (scan_code == CTRL) ctrl_q <= 1'b0;
          end
        endcase
      end
    end
  end

  kbd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(7)
  ) u_fifo (
    .clk  (clk),
    .res  (res),
    .push (push_q),
    .din  (char_q),
    .pop  (clr),
    .full (full),
    .empty(empty),
    .head (head)
  );

  assign kbd      = empty ? 8'h00 : {1'b1, head};
  assign kbd_strb = {~empty, 7'b0};
  assign overflow = ovf_q;
  assign caps     = caps_q;

endmodule

// File: tb/tb_ps2_ascii.sv
// Scoreboard bench for ps2_ascii: expected characters are queued as
// scan codes are sent and popped as the CPU side reads the FIFO.
module tb_ps2_ascii;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] kbd;
  logic [7:0] kbd_strb;
  logic       overflow;
  logic       caps;

  int n_checks = 0;
  int n_fail = 0;
  logic [6:0] sb[$];

  ps2_ascii #(.DEPTH(4)) dut (
    .clk       (clk),
    .res       (res),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .clr       (clr),
    .kbd       (kbd),
    .kbd_strb  (kbd_strb),
    .overflow  (overflow),
    .caps      (caps)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    res = 1'b1;
    @(negedge clk);
    @(negedge clk);
    res = 1'b0;
    sb.delete();
  endtask

  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic [6:0] e;
    int n;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n = 0;
      while (!kbd[7] && n < 8) begin
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (kbd !== {1'b1, e} || kbd_strb !== 8'h80) begin
        n_fail++;
        $display("FAIL %s kbd=%h strb=%h expected kbd=%h strb=80",
                 tag, kbd, kbd_strb, {1'b1, e});
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (kbd !== 8'h00) begin
      n_fail++;
      $display("FAIL %s_empty kbd=%h expected 00", tag, kbd);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (kbd !== 8'h00 || kbd_strb !== 8'h00 || overflow !== 1'b0 || caps !== 1'b0) begin
      n_fail++;
      $display("FAIL reset kbd=%h strb=%h ovf=%b caps=%b expected 00 00 0 0",
               kbd, kbd_strb, overflow, caps);
    end
  endtask

  task automatic test_latency();
    scan_code  = 8'h1C;
    scan_valid = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
    n_checks++;
    if (kbd !== 8'h00) begin
      n_fail++;
      $display("FAIL latency_early kbd=%h expected 00", kbd);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (kbd !== 8'hE1 || kbd_strb !== 8'h80) begin
      n_fail++;
      $display("FAIL latency kbd=%h strb=%h expected E1 80", kbd, kbd_strb);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (kbd !== 8'h00 || kbd_strb !== 8'h00) begin
      n_fail++;
      $display("FAIL latency_clr kbd=%h strb=%h expected 00 00", kbd, kbd_strb);
    end
  endtask

  task automatic test_shift();
    do_reset();
    send(8'h12); send(8'h1C); sb.push_back(7'h41);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    send(8'h1C); sb.push_back(7'h61);
    drain("shift");
  endtask

  task automatic test_caps();
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58);
    n_checks++;
    if (caps !== 1'b1) begin
      n_fail++;
      $display("FAIL caps_on caps=%b expected 1", caps);
    end
    send(8'h1C); sb.push_back(7'h41);
    send(8'h12); send(8'h1C); sb.push_back(7'h61);
    send(8'h16); sb.push_back(7'h21);
    send(8'hF0); send(8'h12);
    send(8'h16); sb.push_back(7'h31);
    send(8'h4A); sb.push_back(7'h2F);
    drain("caps");
    send(8'h58);
    n_checks++;
    if (caps !== 1'b0) begin
      n_fail++;
      $display("FAIL caps_off caps=%b expected 0", caps);
    end
  endtask

  task automatic test_ctrl_fixed();
    do_reset();
    send(8'h14); send(8'h21); sb.push_back(7'h03);
    send(8'hF0); send(8'h14);
    send(8'hE0); send(8'h5A); sb.push_back(7'h0D);
    send(8'hE0); send(8'h75);
    send(8'h66); sb.push_back(7'h08);
    drain("ctrl");
    send(8'hE0); send(8'h14); send(8'h2B); sb.push_back(7'h06);
    send(8'hE0); send(8'hF0); send(8'h14);
    send(8'h2B); sb.push_back(7'h66);
    send(8'h76); sb.push_back(7'h1B);
    send(8'h29); sb.push_back(7'h20);
    drain("fixed");
    send(8'h0D); sb.push_back(7'h09);
    send(8'h5A); sb.push_back(7'h0D);
    send(8'h07);
    send(8'h1A); sb.push_back(7'h7A);
    drain("tab");
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'h4D); sb.push_back(7'h70);
    send(8'h4D); sb.push_back(7'h70);
    send(8'h4D); sb.push_back(7'h70);
    drain("typematic");
  endtask

  task automatic test_overflow();
    do_reset();
    send(8'h1C); sb.push_back(7'h61);
    send(8'h32); sb.push_back(7'h62);
    send(8'h21); sb.push_back(7'h63);
    send(8'h23); sb.push_back(7'h64);
    send(8'h24);
    repeat (2) @(negedge clk);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow ovf=%b expected 1", overflow);
    end
    drain("ovf_order");
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky ovf=%b expected 1", overflow);
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    send(8'h1C);
    send(8'h32); sb.push_back(7'h62);
    send(8'h21); sb.push_back(7'h63);
    send(8'h23); sb.push_back(7'h64);
    @(negedge clk);
    // push reaches the FIFO on the edge after scan_valid; pop on that edge
    scan_code  = 8'h24;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sb.push_back(7'h65);
    repeat (2) @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL pushpop_ovf ovf=%b expected 0", overflow);
    end
    drain("pushpop");
  endtask

  task automatic test_reset_prefix();
    do_reset();
    send(8'h1C);
    repeat (3) @(negedge clk);
    send(8'hE0);
    send(8'hF0);
    #2;
    res = 1'b1;
    #1;
    n_checks++;
    if (kbd !== 8'h00 || kbd_strb !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_prefix kbd=%h strb=%h expected 00 00", kbd, kbd_strb);
    end
    @(negedge clk);
    res = 1'b0;
    sb.delete();
    send(8'h1C); sb.push_back(7'h61);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_shift();
    test_caps();
    test_ctrl_fixed();
    test_back_to_back();
    test_overflow();
    test_full_pushpop();
    test_reset_prefix();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
